// File: rtl/keycode_encoder.sv
// Turns right/left/jump key levels into a PS/2 Set-2 style scancode byte stream
// (make, F0+code break, typematic repeat) behind a valid/ready byte handshake.
module keycode_encoder #(
    parameter logic [7:0]  CODE_RIGHT    = 8'h23,
    parameter logic [7:0]  CODE_LEFT     = 8'h1C,
    parameter logic [7:0]  CODE_JUMP     = 8'h1D,
    parameter int unsigned REPEAT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        right,
    input  logic        left,
    input  logic        jump,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic [15:0] keycode,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SEND_F0, SEND_CODE} state_t;

    localparam int unsigned RPT_LAST   = (REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1;
    localparam logic [23:0] RPT_LAST_V = 24'(RPT_LAST);

    state_t      state, state_n;
    logic [2:0]  in_q;              // {jump, left, right}
    logic [2:0]  rep, rep_n;        // last level actually sent downstream per key
    logic [1:0]  sel_key, sel_key_n;
    logic [7:0]  sel_code, sel_code_n;
    logic        sel_make, sel_make_n;
    logic [23:0] timer, timer_n;
    logic        tx_valid_n;
    logic [7:0]  tx_data_n;
    logic [15:0] keycode_n;
    logic [2:0]  mismatch;
    logic [1:0]  mis_key, held_key;
    logic        xfer;

    function automatic logic [1:0] pick_top(input logic [2:0] m);
        if (m[2])      return 2'd2;
        else if (m[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [7:0] code_of(input logic [1:0] k);
        case (k)
            2'd2:    return CODE_JUMP;
            2'd1:    return CODE_LEFT;
            default: return CODE_RIGHT;
        endcase
    endfunction

    assign mismatch = in_q ^ rep;
    assign mis_key  = pick_top(mismatch);
    assign held_key = pick_top(rep);
    assign xfer     = tx_valid & tx_ready;

    always_comb begin
        state_n    = state;
        rep_n      = rep;
        sel_key_n  = sel_key;
        sel_code_n = sel_code;
        sel_make_n = sel_make;
        timer_n    = timer;
        tx_valid_n = tx_valid;
        tx_data_n  = tx_data;
        keycode_n  = keycode;
        case (state)
            IDLE: begin
                if (mismatch != 3'b000) begin
                    sel_key_n  = mis_key;
                    sel_code_n = code_of(mis_key);
                    sel_make_n = in_q[mis_key];
                    tx_valid_n = 1'b1;
                    tx_data_n  = in_q[mis_key] ? code_of(mis_key) : 8'hF0;
                    state_n    = in_q[mis_key] ? SEND_CODE : SEND_F0;
                end else if (rep != 3'b000) begin
                    if (REPEAT_CYCLES != 0 && timer == RPT_LAST_V) begin
                        // typematic repeat: re-make the highest-priority held key
                        sel_key_n  = held_key;
                        sel_code_n = code_of(held_key);
                        sel_make_n = 1'b1;
                        tx_valid_n = 1'b1;
                        tx_data_n  = code_of(held_key);
                        state_n    = SEND_CODE;
                        timer_n    = 24'd0;
                    end else begin
                        timer_n = timer + 24'd1;
                    end
                end
            end
            SEND_F0: begin
                if (xfer) begin
                    tx_data_n = sel_code;
                    state_n   = SEND_CODE;
                end
            end
            SEND_CODE: begin
                if (xfer) begin
                    tx_valid_n     = 1'b0;
                    state_n        = IDLE;
                    rep_n[sel_key] = sel_make;
                    keycode_n      = {sel_make ? 8'h00 : 8'hF0, sel_code};
                    timer_n        = 24'd0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (rep == 3'b000) timer_n = 24'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_q     <= 3'b000;
            rep      <= 3'b000;
            sel_key  <= 2'd0;
            sel_code <= 8'h00;
            sel_make <= 1'b0;
            timer    <= 24'd0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            keycode  <= 16'h0000;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            in_q     <= {jump, left, right};
            rep      <= rep_n;
            sel_key  <= sel_key_n;
            sel_code <= sel_code_n;
            sel_make <= sel_make_n;
            timer    <= timer_n;
            tx_valid <= tx_valid_n;
            tx_data  <= tx_data_n;
            keycode  <= keycode_n;
            busy     <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_keycode_encoder.sv
// Directed bench for keycode_encoder: one instance without repeat, one with an
// 8-cycle typematic period sharing the same stimulus.
module tb_keycode_encoder;
    logic        clk = 1'b0;
    logic        rst, right, left, jump, tx_ready;
    logic        tx_valid, r_tx_valid;
    logic [7:0]  tx_data, r_tx_data;
    logic [15:0] keycode, r_keycode;
    logic        busy, r_busy;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    keycode_encoder #(.REPEAT_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .right(right), .left(left), .jump(jump),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .keycode(keycode), .busy(busy)
    );

    keycode_encoder #(.REPEAT_CYCLES(8)) dut_r (
        .clk(clk), .rst(rst), .right(right), .left(left), .jump(jump),
        .tx_ready(tx_ready), .tx_valid(r_tx_valid), .tx_data(r_tx_data),
        .keycode(r_keycode), .busy(r_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; right = 1'b0; left = 1'b0; jump = 1'b0; tx_ready = 1'b1;
        tick; tick;
        total++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || keycode !== 16'h0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%b data=%h keycode=%h busy=%b want 0/00/0000/0",
                     tx_valid, tx_data, keycode, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_press_right;
        right = 1'b1;
        tick;
        total++;
        if (tx_valid !== 1'b0) begin
            bad++; $display("FAIL press_latency1: valid=%b want 0", tx_valid);
        end
        tick;
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h23 || busy !== 1'b1) begin
            bad++; $display("FAIL press_make: valid=%b data=%h busy=%b want 1/23/1", tx_valid, tx_data, busy);
        end
        tick;
        total++;
        if (tx_valid !== 1'b0 || keycode !== 16'h0023 || busy !== 1'b0) begin
            bad++; $display("FAIL press_keycode: valid=%b keycode=%h busy=%b want 0/0023/0", tx_valid, keycode, busy);
        end
        for (int i = 0; i < 5; i++) begin
            tick;
            total++;
            if (tx_valid !== 1'b0) begin
                bad++; $display("FAIL press_single_byte: cycle %0d valid=%b want 0", i, tx_valid);
            end
        end
    endtask

    task automatic test_release_right;
        right = 1'b0;
        tick; tick;
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hF0) begin
            bad++; $display("FAIL release_f0: valid=%b data=%h want 1/F0", tx_valid, tx_data);
        end
        tick;
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h23) begin
            bad++; $display("FAIL release_code: valid=%b data=%h want 1/23", tx_valid, tx_data);
        end
        tick;
        total++;
        if (tx_valid !== 1'b0 || keycode !== 16'hF023) begin
            bad++; $display("FAIL release_keycode: valid=%b keycode=%h want 0/F023", tx_valid, keycode);
        end
        tick; tick;
        total++;
        if (tx_valid !== 1'b0) begin
            bad++; $display("FAIL release_quiet: valid=%b want 0", tx_valid);
        end
    endtask

    task automatic test_simultaneous;
        logic [7:0] codes [3];
        codes = '{8'h1D, 8'h1C, 8'h23};
        jump = 1'b1; left = 1'b1; right = 1'b1;
        tick;
        for (int k = 0; k < 3; k++) begin
            tick;
            total++;
            if (tx_valid !== 1'b1 || tx_data !== codes[k]) begin
                bad++; $display("FAIL simul_make%0d: valid=%b data=%h want 1/%h", k, tx_valid, tx_data, codes[k]);
            end
            tick;
            total++;
            if (tx_valid !== 1'b0 || keycode !== {8'h00, codes[k]}) begin
                bad++; $display("FAIL simul_gap%0d: valid=%b keycode=%h want 0/00%h", k, tx_valid, keycode, codes[k]);
            end
        end
    endtask

    task automatic test_stall;
        tx_ready = 1'b0;
        jump = 1'b0;
        tick; tick;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hF0) begin
                bad++; $display("FAIL stall_hold: cycle %0d valid=%b data=%h want 1/F0", i, tx_valid, tx_data);
            end
            tick;
        end
        tx_ready = 1'b1;
        tick;
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h1D) begin
            bad++; $display("FAIL stall_code: valid=%b data=%h want 1/1D", tx_valid, tx_data);
        end
        tick;
        total++;
        if (tx_valid !== 1'b0 || keycode !== 16'hF01D) begin
            bad++; $display("FAIL stall_keycode: valid=%b keycode=%h want 0/F01D", tx_valid, keycode);
        end
    endtask

    task automatic test_reset_mid;
        tx_ready = 1'b0;
        left = 1'b0;
        tick; tick;
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hF0) begin
            bad++; $display("FAIL midrst_f0: valid=%b data=%h want 1/F0", tx_valid, tx_data);
        end
        rst = 1'b1;
        tick;
        total++;
        if (tx_valid !== 1'b0 || keycode !== 16'h0000 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_clear: valid=%b keycode=%h busy=%b want 0/0000/0", tx_valid, keycode, busy);
        end
        rst = 1'b0;
        tx_ready = 1'b1;
        tick; tick;
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h23) begin
            bad++; $display("FAIL midrst_remake: valid=%b data=%h want 1/23", tx_valid, tx_data);
        end
        tick;
        total++;
        if (tx_valid !== 1'b0 || keycode !== 16'h0023) begin
            bad++; $display("FAIL midrst_keycode: valid=%b keycode=%h want 0/0023", tx_valid, keycode);
        end
    endtask

    task automatic test_repeat;
        rst = 1'b1; right = 1'b0; left = 1'b0; jump = 1'b0; tx_ready = 1'b1;
        tick;
        rst = 1'b0;
        jump = 1'b1;
        tick; tick;
        total++;
        if (r_tx_valid !== 1'b1 || r_tx_data !== 8'h1D || tx_valid !== 1'b1 || tx_data !== 8'h1D) begin
            bad++; $display("FAIL repeat_first: r=%b/%h norep=%b/%h want 1/1D both",
                            r_tx_valid, r_tx_data, tx_valid, tx_data);
        end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                tick;
                total++;
                if (r_tx_valid !== 1'b0 || tx_valid !== 1'b0) begin
                    bad++; $display("FAIL repeat_idle%0d_%0d: r_valid=%b norep_valid=%b want 0/0",
                                    r, i, r_tx_valid, tx_valid);
                end
            end
            tick;
            total++;
            if (r_tx_valid !== 1'b1 || r_tx_data !== 8'h1D || tx_valid !== 1'b0) begin
                bad++; $display("FAIL repeat_fire%0d: r=%b/%h norep_valid=%b want 1/1D and 0",
                                r, r_tx_valid, r_tx_data, tx_valid);
            end
        end
        tick;
        total++;
        if (r_keycode !== 16'h001D || keycode !== 16'h001D) begin
            bad++; $display("FAIL repeat_keycode: r=%h norep=%h want 001D", r_keycode, keycode);
        end
    endtask

    initial begin
        test_reset;
        test_press_right;
        test_release_right;
        test_simultaneous;
        test_stall;
        test_reset_mid;
        test_repeat;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
